// File: rtl/shift_pkg.sv
// shift_pkg: shared encodings and constants for the iterative shifter
package shift_pkg;

   typedef enum logic [1:0] {
      MODE_LSL = 2'b00,
      MODE_LSR = 2'b01,
      MODE_ASR = 2'b10,
      MODE_ROR = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   localparam int MAX_STEP = 3;

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational 0-3 bit shift/rotate stage, one 4:1 mux per bit
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 33
) (
   input  logic [WIDTH-1:0] data,
   input  mode_e            mode,
   input  logic [1:0]       step,
   output logic [WIDTH-1:0] q
);

   // Bits entering from above the MSB: sign copies for ASR, zeros for LSR.
   logic fill;
   assign fill = (mode == MODE_ASR) & data[WIDTH-1];

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [3:0] cand;
      for (genvar s = 0; s < 4; s++) begin : g_s
         logic lsl_b, rgt_b, ror_b;
         if (i >= s) begin : g_lsl
            assign lsl_b = data[i-s];
         end else begin : g_lsl_fill
            assign lsl_b = 1'b0;
         end
         if (i + s < WIDTH) begin : g_rgt
            assign rgt_b = data[i+s];
         end else begin : g_rgt_fill
            assign rgt_b = fill;
         end
         assign ror_b   = data[(i+s)%WIDTH];
         assign cand[s] = (mode == MODE_LSL) ? lsl_b : (mode == MODE_ROR) ? ror_b : rgt_b;
      end
      assign q[i] = cand[step];
   end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter retiring up to three bit positions per cycle
module iter_shifter
   import shift_pkg::*;
#(
   parameter int WIDTH   = 33,
   parameter int SHAMT_W = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               op_start,
   input  logic               op_clear,
   input  logic [1:0]         mode,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   d_in,
   output logic [WIDTH-1:0]   d_out,
   output logic               busy,
   output logic               done
);

   state_e             state, state_n;
   mode_e              mode_q, mode_n;
   logic [SHAMT_W-1:0] rem, rem_n;
   logic [WIDTH-1:0]   res_n, stepped;
   logic [1:0]         step;

   assign step = (rem >= SHAMT_W'(MAX_STEP)) ? 2'(MAX_STEP) : rem[1:0];

   shift_step #(.WIDTH(WIDTH)) u_step (
      .data (d_out),
      .mode (mode_q),
      .step (step),
      .q    (stepped)
   );

   // Next-state: clear beats start, start only outside SHIFT, else iterate.
   always_comb begin
      state_n = state;
      rem_n   = rem;
      res_n   = d_out;
      mode_n  = mode_q;
      if (op_clear) begin
         state_n = ST_IDLE;
         rem_n   = '0;
         res_n   = '0;
      end else if (op_start && state != ST_SHIFT) begin
         res_n   = d_in;
         rem_n   = shamt;
         mode_n  = mode_e'(mode);
         state_n = (shamt != '0) ? ST_SHIFT : ST_DONE;
      end else if (state == ST_SHIFT) begin
         res_n   = stepped;
         rem_n   = rem - SHAMT_W'(step);
         state_n = (rem_n == '0) ? ST_DONE : ST_SHIFT;
      end
   end

   // State, operand registers and registered status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         rem    <= '0;
         mode_q <= MODE_LSL;
         d_out  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         rem    <= rem_n;
         mode_q <= mode_n;
         d_out  <= res_n;
         busy   <= (state_n == ST_SHIFT);
         done   <= (state_n == ST_DONE);
      end
   end

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: randomized self-checking bench against an arithmetic reference model
module tb_iter_shifter;

   localparam int W  = 33;
   localparam int SW = 6;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          op_start = 1'b0;
   logic          op_clear = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [SW-1:0] shamt = '0;
   logic [W-1:0]  d_in = '0;
   logic [W-1:0]  d_out;
   logic          busy, done;

   int checks = 0;
   int errors = 0;

   iter_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .op_start (op_start),
      .op_clear (op_clear),
      .mode     (mode),
      .shamt    (shamt),
      .d_in     (d_in),
      .d_out    (d_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_shift(input logic [1:0] m, input int sh, input logic [W-1:0] d);
      logic signed [W-1:0] sd;
      int r;
      sd = d;
      r  = sh % W;
      case (m)
         2'b00:   return d << sh;
         2'b01:   return d >> sh;
         2'b10:   return sd >>> sh;
         default: return (d >> r) | (d << (W - r));
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at a sample point; the accept happens on the next edge.
   task automatic run_op(input string tag, input logic [1:0] m, input int sh, input logic [W-1:0] d);
      int nb, guard;
      op_start = 1'b1;
      mode     = m;
      shamt    = SW'(sh);
      d_in     = d;
      tick();
      op_start = 1'b0;
      nb = 0;
      guard = 0;
      while (!done && guard < 100) begin
         if (busy) nb++;
         if (busy && done) check({tag, " busy&done"}, 1, 0);
         tick();
         guard++;
      end
      check({tag, " done"}, done, 1'b1);
      check({tag, " busy_cycles"}, nb, (sh + 2) / 3);
      check({tag, " d_out"}, d_out, ref_shift(m, sh, d));
   endtask

   initial begin
      #2;
      check("reset d_out", d_out, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      tick();
      reset_n = 1'b1;
      tick();
      check("idle done", done, 0);

      run_op("lsl7",  2'b00, 7,  33'h0_0000_0001);
      check("lsl7 value", d_out, 33'h0_0000_0080);
      run_op("lsr32", 2'b01, 32, 33'h1_0000_0000);
      check("lsr32 value", d_out, 33'h0_0000_0001);
      run_op("asr4",  2'b10, 4,  33'h1_0000_0000);
      check("asr4 value", d_out, 33'h1_F000_0000);
      run_op("asr40", 2'b10, 40, 33'h1_0000_0000);
      check("asr40 value", d_out, 33'h1_FFFF_FFFF);
      run_op("ror1",  2'b11, 1,  33'h0_0000_0001);
      check("ror1 value", d_out, 33'h1_0000_0000);
      run_op("ror34", 2'b11, 34, 33'h0_0000_0001);
      check("ror34 value", d_out, 33'h1_0000_0000);
      run_op("zero",  2'b01, 0,  33'h0_1234_5678);
      check("zero value", d_out, 33'h0_1234_5678);
      run_op("lsl63", 2'b00, 63, 33'h1_FFFF_FFFF);
      run_op("ror63", 2'b11, 63, 33'h1_2345_6789);

      // Re-accept straight out of DONE: next cycle must already be SHIFT.
      op_start = 1'b1; mode = 2'b01; shamt = 6'd9; d_in = 33'h1_8000_0000;
      tick();
      op_start = 1'b0;
      check("reaccept busy", busy, 1);
      check("reaccept done", done, 0);
      tick(); tick(); tick();
      check("reaccept result", d_out, ref_shift(2'b01, 9, 33'h1_8000_0000));
      check("reaccept fin", done, 1);

      // op_start during SHIFT is ignored.
      op_start = 1'b1; mode = 2'b00; shamt = 6'd30; d_in = 33'h0_0000_0003;
      tick();
      op_start = 1'b0;
      tick();
      op_start = 1'b1; mode = 2'b11; shamt = 6'd1; d_in = 33'h1_FFFF_0000;
      tick();
      op_start = 1'b0;
      for (int i = 0; i < 20 && !done; i++) tick();
      check("ignore result", d_out, ref_shift(2'b00, 30, 33'h0_0000_0003));

      // op_clear mid-SHIFT.
      tick();
      op_start = 1'b1; mode = 2'b10; shamt = 6'd50; d_in = 33'h1_2345_6789;
      tick();
      op_start = 1'b0;
      tick();
      op_clear = 1'b1;
      tick();
      op_clear = 1'b0;
      check("clear d_out", d_out, 0);
      check("clear busy", busy, 0);
      check("clear done", done, 0);

      // op_clear wins over op_start in DONE.
      run_op("pre", 2'b00, 2, 33'h0_0000_0005);
      op_start = 1'b1; op_clear = 1'b1; shamt = 6'd0; d_in = 33'h0_0000_00AA;
      tick();
      op_start = 1'b0; op_clear = 1'b0;
      check("clr_pri done", done, 0);
      check("clr_pri d_out", d_out, 0);

      // Asynchronous reset mid-SHIFT.
      op_start = 1'b1; mode = 2'b00; shamt = 6'd40; d_in = 33'h0_0000_0001;
      tick();
      op_start = 1'b0;
      tick();
      #2 reset_n = 1'b0;
      #1;
      check("areset d_out", d_out, 0);
      check("areset busy", busy, 0);
      check("areset done", done, 0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (done || busy) check("post_reset idle", {busy, done}, 0);
      end

      for (int n = 0; n < 60; n++) begin
         logic [W-1:0] d;
         d = {$urandom, $urandom};
         run_op("rand", 2'($urandom_range(0, 3)), int'($urandom_range(0, 63)), d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
